ibm1620_timing_ring: RTL and testbench
======================================

# ibm1620_timing_ring

Consumer end of the two-phase machine clock built from the SMS oscillator, binary trigger and 2-way inverter cards. It samples the complementary phase pair (clk_a, clk_b) in the fast simulation clock and advances a one-hot timing ring of memory-cycle positions on each clk_a rising edge. It also checks the pair for protocol faults: overlap or gap, lost clock, phase out of order. It sits between the clock-generation card models and the memory/core cycle logic, which gates on `t_gate`.

## Interface
- `RING_LEN`, 10 — timing positions per memory cycle (2..16).
- `GAP_MAX`, 4 — max consecutive clk cycles with phase_a == phase_b before fault.
- `TIMEOUT`, 64 — max clk cycles without any synchronized phase edge while armed/running.
- `clk`  in  1  simulation/system clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `phase_a`  in  1  clk_a from inverter card, asynchronous to clk.
- `phase_b`  in  1  clk_b, nominal complement of phase_a.
- `start`  in  1  level-sampled request; begins ring (also clears fault).
- `stop`  in  1  request stop at end of current memory cycle.
- `busy`  out  1  high in ARM, RUN, STOPPING.
- `t_gate`  out  RING_LEN  one-hot current position; all-zero when not RUN/STOPPING.
- `t_pos`  out  4  binary index of current position.
- `cycle_end`  out  1  one-clk pulse on wrap RING_LEN-1 -> 0.
- `cycle_count`  out  16  completed memory cycles, wraps 0xFFFF -> 0.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  0 none, 1 overlap/gap, 2 timeout, 3 order error.

## Operation
- Two-flop synchronizer on phase_a and phase_b, then a third register for edge detection. Edges: a_rise, b_rise.
- States:
  - IDLE: outputs quiet. `start` -> ARM.
  - ARM: wait for first a_rise -> RUN with t_pos = 0, t_gate = 1.
  - RUN: each a_rise advances t_pos by 1 modulo RING_LEN. On wrap, pulse cycle_end and increment cycle_count. `stop` latches a stop_pending bit -> STOPPING.
  - STOPPING: identical to RUN until the next wrap. On that wrap: pulse cycle_end, count, -> IDLE, t_gate = 0, t_pos = 0.
  - FAULT: t_gate = 0, busy = 0; fault and fault_code hold. `start` -> ARM with fault cleared.
- Order rule: after an a_rise, the next phase edge that counts must be b_rise. Two a_rise without an intervening b_rise -> FAULT code 3. The first a_rise in ARM is exempt.
- Gap/overlap: in ARM/RUN/STOPPING, phase_a == phase_b (synchronized) for more than GAP_MAX consecutive clk cycles -> FAULT code 1.
- Timeout: watchdog counter resets on any a_rise or b_rise. Exceeding TIMEOUT in ARM/RUN/STOPPING -> FAULT code 2.
- Fault priority when several occur in the same clk: code 1 > 2 > 3.
- `start` while busy is ignored. `stop` in IDLE or ARM: in ARM it returns to IDLE immediately; in IDLE it is ignored.
- Reset mid-cycle: all state cleared next clk, no cycle_end pulse.

## Timing
- All outputs are registered. Reset values: busy 0, t_gate 0, t_pos 0, cycle_end 0, cycle_count 0, fault 0, fault_code 0.
- Latency from a phase_a pin rising edge to the t_gate/t_pos update is 3 clk cycles (2 sync + 1 edge/register). cycle_end is coincident with t_pos returning to 0.
- A fault is flagged 1 clk after its detection condition becomes true in the synchronized domain.
- Phase high and low times must each be ≥ 3 clk cycles for guaranteed edge capture.

## Structure
- Shared package `ibm1620_timing_pkg`: state enum (IDLE, ARM, RUN, STOPPING, FAULT), fault code constants, default RING_LEN.
- One sub-module `sms_sync_edge`: 2-flop synchronizer plus rise detector, instantiated twice.

## Test plan
- Reset, then start; 1 MHz oscillator through the trigger (2 µs phase period) -> after the first a_rise t_pos = 0. After 10 a_rises, cycle_end pulses once and cycle_count = 1.
- stop asserted at t_pos = 4 -> ring continues to 9 then 0, cycle_end pulses, busy = 0, t_gate = 0.
- Hold phase_a = phase_b = 1 for 5 clk cycles while running -> fault = 1, fault_code = 1, t_gate = 0. start -> fault cleared, state ARM.
- Freeze both phases in complementary state for 65 clk cycles -> fault_code = 2.
- Suppress one clk_b pulse (two a_rise back-to-back) -> fault_code = 3.
- Preload cycle_count by running 65535 cycles (or force) -> next wrap gives cycle_count = 0. rst asserted at t_pos = 6 -> all outputs 0 the next clk.

Source files
------------

// File: rtl/ibm1620_timing_pkg.sv
// Shared types and constants for the IBM 1620 two-phase clock consumer.
package ibm1620_timing_pkg;

    localparam int unsigned RING_LEN_DEFAULT = 10;
    localparam int unsigned POS_W            = 4;
    localparam int unsigned COUNT_W          = 16;
    localparam int unsigned FCODE_W          = 2;

    localparam logic [FCODE_W-1:0] FC_NONE    = 2'd0;
    localparam logic [FCODE_W-1:0] FC_GAP     = 2'd1;
    localparam logic [FCODE_W-1:0] FC_TIMEOUT = 2'd2;
    localparam logic [FCODE_W-1:0] FC_ORDER   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_STOPPING,
        ST_FAULT
    } ring_state_t;

endpackage

// File: rtl/sms_sync_edge.sv
// Two-flop synchronizer for one clock phase line plus a rising-edge detector.
module sms_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            meta  <= din;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise_c = level & ~prev;

endmodule

// File: rtl/ibm1620_timing_ring.sv
// One-hot memory-cycle timing ring driven by the clk_a/clk_b phase pair,
// with overlap/gap, lost-clock and phase-order fault detection.
module ibm1620_timing_ring
    import ibm1620_timing_pkg::*;
#(
    parameter int unsigned RING_LEN = RING_LEN_DEFAULT,
    parameter int unsigned GAP_MAX  = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                phase_a,
    input  logic                phase_b,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic [RING_LEN-1:0] t_gate,
    output logic [POS_W-1:0]    t_pos,
    output logic                cycle_end,
    output logic [COUNT_W-1:0]  cycle_count,
    output logic                fault,
    output logic [FCODE_W-1:0]  fault_code
);

    localparam int unsigned GAP_W = $clog2(GAP_MAX + 1) + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1) + 1;

    logic a_lvl, a_rise, b_lvl, b_rise;

    sms_sync_edge u_sync_a (
        .clk    (clk),
        .rst    (rst),
        .din    (phase_a),
        .level  (a_lvl),
        .rise_c (a_rise)
    );

    sms_sync_edge u_sync_b (
        .clk    (clk),
        .rst    (rst),
        .din    (phase_b),
        .level  (b_lvl),
        .rise_c (b_rise)
    );

    ring_state_t          state, state_nxt;
    logic [GAP_W-1:0]     gap_cnt, gap_nxt;
    logic [WD_W-1:0]      wd_cnt, wd_nxt;
    logic                 need_b, need_b_nxt;
    logic [POS_W-1:0]     t_pos_nxt, adv_pos;
    logic [RING_LEN-1:0]  t_gate_nxt;
    logic [COUNT_W-1:0]   count_nxt;
    logic                 busy_nxt, end_nxt, fault_nxt;
    logic [FCODE_W-1:0]   code_nxt, flt;
    logic                 active, at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            need_b      <= 1'b0;
            busy        <= 1'b0;
            t_gate      <= '0;
            t_pos       <= '0;
            cycle_end   <= 1'b0;
            cycle_count <= '0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_nxt;
            wd_cnt      <= wd_nxt;
            need_b      <= need_b_nxt;
            busy        <= busy_nxt;
            t_gate      <= t_gate_nxt;
            t_pos       <= t_pos_nxt;
            cycle_end   <= end_nxt;
            cycle_count <= count_nxt;
            fault       <= fault_nxt;
            fault_code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gap_nxt    = '0;
        wd_nxt     = '0;
        need_b_nxt = need_b;
        t_pos_nxt  = t_pos;
        count_nxt  = cycle_count;
        end_nxt    = 1'b0;
        fault_nxt  = fault;
        code_nxt   = fault_code;
        flt        = FC_NONE;
        active     = (state == ST_ARM) || (state == ST_RUN) || (state == ST_STOPPING);
        at_last    = (t_pos == POS_W'(RING_LEN - 1));
        adv_pos    = at_last ? '0 : t_pos + POS_W'(1);

        // Protocol watchdogs run only while the ring is armed or turning.
        if (active) begin
            gap_nxt = (a_lvl == b_lvl) ? gap_cnt + GAP_W'(1) : '0;
            wd_nxt  = (a_rise || b_rise) ? '0 : wd_cnt + WD_W'(1);
            if ((a_lvl == b_lvl) && (gap_cnt >= GAP_W'(GAP_MAX))) begin
                flt = FC_GAP;
            end else if (!(a_rise || b_rise) && (wd_cnt >= WD_W'(TIMEOUT))) begin
                flt = FC_TIMEOUT;
            end else if (a_rise && need_b && (state != ST_ARM)) begin
                flt = FC_ORDER;
            end
        end

        if (flt != FC_NONE) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
            code_nxt  = flt;
            t_pos_nxt = '0;
            gap_nxt   = '0;
            wd_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        state_nxt  = ST_ARM;
                        fault_nxt  = 1'b0;
                        code_nxt   = FC_NONE;
                        need_b_nxt = 1'b0;
                        t_pos_nxt  = '0;
                    end
                end
                ST_ARM: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end else if (a_rise) begin
                        state_nxt  = ST_RUN;
                        t_pos_nxt  = '0;
                        need_b_nxt = 1'b1;
                    end
                end
                ST_RUN, ST_STOPPING: begin
                    if (b_rise) begin
                        need_b_nxt = 1'b0;
                    end
                    if (a_rise) begin
                        need_b_nxt = 1'b1;
                        t_pos_nxt  = adv_pos;
                        if (at_last) begin
                            end_nxt   = 1'b1;
                            count_nxt = cycle_count + COUNT_W'(1);
                            if (state == ST_STOPPING) begin
                                state_nxt = ST_IDLE;
                            end
                        end
                    end
                    if ((state == ST_RUN) && stop) begin
                        state_nxt = ST_STOPPING;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    t_pos_nxt = '0;
                end
            endcase
        end

        busy_nxt   = (state_nxt == ST_ARM) || (state_nxt == ST_RUN) || (state_nxt == ST_STOPPING);
        t_gate_nxt = ((state_nxt == ST_RUN) || (state_nxt == ST_STOPPING))
                     ? (RING_LEN'(1) << t_pos_nxt) : '0;
    end

endmodule

// File: tb/tb_ibm1620_timing_ring.sv
// Directed bench for ibm1620_timing_ring with a cycle-level reference model.
`timescale 1ns/1ps
module tb_ibm1620_timing_ring;

    localparam int RL = 10;
    localparam int GM = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          phase_a = 1'b0;
    logic          phase_b = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic [RL-1:0] t_gate;
    logic [3:0]    t_pos;
    logic          cycle_end;
    logic [15:0]   cycle_count;
    logic          fault;
    logic [1:0]    fault_code;

    int compared = 0;
    int mismatched = 0;
    int end_pulses = 0;

    ibm1620_timing_ring #(.RING_LEN(RL), .GAP_MAX(GM), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .phase_a     (phase_a),
        .phase_b     (phase_b),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .t_gate      (t_gate),
        .t_pos       (t_pos),
        .cycle_end   (cycle_end),
        .cycle_count (cycle_count),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #50 clk = ~clk;

    // Reference model: mode 0 idle, 1 armed, 2 running, 3 stopping, 4 faulted.
    int        m_mode = 0;
    int        m_rises = 0;
    int        m_eq_run = 0;
    int        m_quiet = 0;
    bit        m_await_b = 0;
    bit [15:0] m_count = 0;
    bit        m_end = 0;
    bit        m_fault = 0;
    bit [1:0]  m_code = 0;
    bit        pa1 = 0, pa2 = 0, pa3 = 0, pb1 = 0, pb2 = 0, pb3 = 0;

    always @(posedge clk) begin : model
        bit ra, rb, act;
        int code;
        if (rst) begin
            m_mode = 0; m_rises = 0; m_eq_run = 0; m_quiet = 0; m_await_b = 0;
            m_count = 0; m_end = 0; m_fault = 0; m_code = 0;
            pa1 = 0; pa2 = 0; pa3 = 0; pb1 = 0; pb2 = 0; pb3 = 0;
        end else begin
            ra = pa2 && !pa3;
            rb = pb2 && !pb3;
            m_end = 0;
            act = (m_mode >= 1) && (m_mode <= 3);
            if (act) begin
                m_eq_run = (pa2 == pb2) ? m_eq_run + 1 : 0;
                m_quiet  = (ra || rb) ? 0 : m_quiet + 1;
                code = 0;
                if (m_eq_run > GM) code = 1;
                else if (m_quiet > TO) code = 2;
                else if (ra && m_await_b && m_mode != 1) code = 3;
                if (code != 0) begin
                    m_mode = 4; m_fault = 1; m_code = 2'(code);
                end else if (m_mode == 1) begin
                    if (stop) m_mode = 0;
                    else if (ra) begin m_mode = 2; m_rises = 0; m_await_b = 1; end
                end else begin
                    if (rb) m_await_b = 0;
                    if (ra) begin
                        m_rises++;
                        m_await_b = 1;
                        if (m_rises % RL == 0) begin
                            m_end = 1;
                            m_count = m_count + 16'd1;
                            if (m_mode == 3) m_mode = 0;
                        end
                    end
                    if (m_mode == 2 && stop) m_mode = 3;
                end
            end else if (start) begin
                m_mode = 1; m_fault = 0; m_code = 0;
                m_eq_run = 0; m_quiet = 0; m_await_b = 0;
            end
            pa3 = pa2; pa2 = pa1; pa1 = phase_a;
            pb3 = pb2; pb2 = pb1; pb1 = phase_b;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        bit        e_run;
        bit [3:0]  e_pos;
        bit [RL-1:0] e_gate;
        logic [34:0] act_v, exp_v;
        e_run  = (m_mode == 2) || (m_mode == 3);
        e_pos  = e_run ? 4'(m_rises % RL) : 4'd0;
        e_gate = e_run ? (RL'(1) << e_pos) : '0;
        exp_v  = {((m_mode >= 1) && (m_mode <= 3)), e_gate, e_pos, m_end, m_count, m_fault, m_code};
        act_v  = {busy, t_gate, t_pos, cycle_end, cycle_count, fault, fault_code};
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("FAIL cycle_check t=%0t got busy=%b gate=%b pos=%0d end=%b cnt=%h flt=%b code=%0d want busy=%b gate=%b pos=%0d end=%b cnt=%h flt=%b code=%0d",
                     $time, busy, t_gate, t_pos, cycle_end, cycle_count, fault, fault_code,
                     exp_v[34], e_gate, e_pos, m_end, m_count, m_fault, m_code);
        end
        if (cycle_end === 1'b1) end_pulses++;
    end

    task automatic check_lit(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic half(input logic av, input logic bv, input int n);
        phase_a = av;
        phase_b = bv;
        repeat (n) @(negedge clk);
    endtask

    task automatic period();
        half(1'b1, 1'b0, 10);
        half(1'b0, 1'b1, 10);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_lit("reset_busy", int'(busy), 0);
        check_lit("reset_gate", int'(t_gate), 0);
        check_lit("reset_count", int'(cycle_count), 0);
        rst = 1'b0;
        @(negedge clk);

        // First memory cycle and wrap.
        pulse_start();
        check_lit("arm_busy", int'(busy), 1);
        half(1'b1, 1'b0, 10);
        check_lit("first_rise_pos", int'(t_pos), 0);
        check_lit("first_rise_gate", int'(t_gate), 1);
        half(1'b0, 1'b1, 10);
        repeat (9) period();
        half(1'b1, 1'b0, 10);
        check_lit("wrap_count", int'(cycle_count), 1);
        check_lit("wrap_pos", int'(t_pos), 0);
        half(1'b0, 1'b1, 10);

        // Stop requested at position 4 finishes the cycle then idles.
        repeat (3) period();
        half(1'b1, 1'b0, 10);
        check_lit("pre_stop_pos", int'(t_pos), 4);
        stop = 1'b1;
        half(1'b0, 1'b1, 1);
        stop = 1'b0;
        half(1'b0, 1'b1, 9);
        repeat (5) period();
        half(1'b1, 1'b0, 10);
        check_lit("stop_busy", int'(busy), 0);
        check_lit("stop_gate", int'(t_gate), 0);
        check_lit("stop_count", int'(cycle_count), 2);
        check_lit("stop_end_pulses", end_pulses, 2);
        half(1'b0, 1'b1, 10);

        // Overlap fault, then restart clears it.
        pulse_start();
        repeat (3) period();
        half(1'b1, 1'b1, 12);
        check_lit("gap_fault", int'(fault), 1);
        check_lit("gap_code", int'(fault_code), 1);
        check_lit("gap_gate", int'(t_gate), 0);
        half(1'b0, 1'b1, 2);
        pulse_start();
        check_lit("gap_clear_fault", int'(fault), 0);
        check_lit("gap_rearm_busy", int'(busy), 1);

        // Lost clock.
        repeat (2) period();
        half(1'b1, 1'b0, 75);
        check_lit("timeout_code", int'(fault_code), 2);
        half(1'b0, 1'b1, 3);
        pulse_start();

        // Missing clk_b pulse.
        repeat (2) period();
        half(1'b1, 1'b0, 10);
        half(1'b0, 1'b0, 3);
        half(1'b1, 1'b0, 10);
        check_lit("order_fault", int'(fault), 1);
        check_lit("order_code", int'(fault_code), 3);
        half(1'b0, 1'b1, 5);
        pulse_start();

        // Cycle counter rollover via a preloaded count.
        half(1'b1, 1'b0, 10);
        half(1'b0, 1'b1, 5);
        #5;
        force dut.cycle_count = 16'hFFFF;
        m_count = 16'hFFFF;
        @(negedge clk);
        #5;
        release dut.cycle_count;
        repeat (4) @(negedge clk);
        repeat (9) period();
        half(1'b1, 1'b0, 10);
        check_lit("rollover_count", int'(cycle_count), 0);
        half(1'b0, 1'b1, 10);

        // Reset in the middle of a cycle.
        repeat (5) period();
        half(1'b1, 1'b0, 10);
        check_lit("pre_reset_pos", int'(t_pos), 6);
        rst = 1'b1;
        @(negedge clk);
        check_lit("rst_busy", int'(busy), 0);
        check_lit("rst_pos", int'(t_pos), 0);
        check_lit("rst_gate", int'(t_gate), 0);
        check_lit("rst_end", int'(cycle_end), 0);
        check_lit("rst_count", int'(cycle_count), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
